// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx : UART transmitter
//
// Turns parallel words into a serial frame on tx:
//   start bit, DBIT data bits LSB first, an optional parity bit, then stop bits.
// Timing comes from the shared 16x-oversampling baud tick s_tick, so every bit
// lasts 16 ticks. The stop phase lasts SB_TICK ticks. A valid/ready handshake
// accepts one word per frame, and only while the transmitter is idle.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : a parity bit follows the data bits. PARITY_ODD selects odd parity.
//   undefined : no parity state and no parity logic.
//
// Parameters
//   DBIT        data bits per frame (5..9)
//   SB_TICK     s_ticks spent in the stop state (16, 24 or 32)
//   PARITY_ODD  0 = even parity, 1 = odd parity (used only with the macro)
//
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous, active-low reset
//   s_tick        in   1-clk baud tick, 16 per bit period
//   tx_valid      in   din holds a word to send
//   din           in   word to transmit (DBIT bits)
//   tx_ready      out  a word can be accepted (high only in IDLE)
//   tx            out  registered serial line, idles high
//   tx_busy       out  a frame is in progress
//   tx_done_tick  out  1-clk pulse on the final stop-bit tick
// ----------------------------------------------------------------------------
module uart_tx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_valid,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // The tick counter must reach SB_TICK-1 in the stop state. Every other
  // state counts only to 15, so the counter is never narrower than 4 bits.
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  // Reject configurations that the frame format cannot represent.
  if (DBIT < 5 || DBIT > 9 || SB_TICK < 16 || SB_TICK > 32 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParam
    $error("uart_tx: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  // State register. All registers reset asynchronously, so the line returns
  // to idle-high as soon as reset_n falls, even in the middle of a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic. A tick that arrives in the accept cycle is not counted:
  // counting begins once the FSM is in START. The parity bit is computed from
  // din when the word is accepted, because b is shifted away while it is sent.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          s_d     = '0;
          b_d     = din;
`ifdef UART_TX_PARITY_EN
          par_d   = (^din) ^ (PARITY_ODD != 0);
`endif
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            s_d     = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The next line level comes from the current state and is then
  // registered, so tx follows a state change one clock later and never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
    tx_ready     = (state_q == IDLE);
    tx_busy      = (state_q != IDLE);
    tx_done_tick = (state_q == STOP) && s_tick && (s_q == SW'(SB_TICK - 1));
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx : self-checking bench for uart_tx
//
// Main DUT: DBIT=8, SB_TICK=16, with a programmable s_tick divider.
// Second DUT: SB_TICK=32 with s_tick held high, used for the long-stop frame.
// With UART_TX_PARITY_EN defined, an even-parity DUT and an odd-parity DUT
// are added as well.
// Frames are captured by sampling tx in the middle of each bit period.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sTick = 1'b0;
  logic       txValid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       txReady, txLine, txBusy, txDone;

  logic       fastTick = 1'b1;
  logic       bValid = 1'b0;
  logic [7:0] bDin = 8'h00;
  logic       bReady, bTx, bBusy, bDone;

  int errors = 0;
  int checks = 0;
  int tickDiv = 1;
  int tickCnt = 0;
  int doneTotal = 0;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(sTick), .tx_valid(txValid), .din(din),
    .tx_ready(txReady), .tx(txLine), .tx_busy(txBusy), .tx_done_tick(txDone));

  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY_ODD(0)) dutLong (
    .clk(clk), .reset_n(reset_n), .s_tick(fastTick), .tx_valid(bValid), .din(bDin),
    .tx_ready(bReady), .tx(bTx), .tx_busy(bBusy), .tx_done_tick(bDone));

`ifdef UART_TX_PARITY_EN
  logic       pValid = 1'b0;
  logic [7:0] pDin = 8'h00;
  logic       peReady, peTx, peBusy, peDone;
  logic       poReady, poTx, poBusy, poDone;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dutEven (
    .clk(clk), .reset_n(reset_n), .s_tick(fastTick), .tx_valid(pValid), .din(pDin),
    .tx_ready(peReady), .tx(peTx), .tx_busy(peBusy), .tx_done_tick(peDone));

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1)) dutOdd (
    .clk(clk), .reset_n(reset_n), .s_tick(fastTick), .tx_valid(pValid), .din(pDin),
    .tx_ready(poReady), .tx(poTx), .tx_busy(poBusy), .tx_done_tick(poDone));
`endif

  // Baud tick: a one-clock pulse every tickDiv clocks, changed well away from
  // both clock edges.
  always @(posedge clk) begin
    #2;
    if (tickDiv <= 1) begin
      sTick = 1'b1;
    end else begin
      sTick   = (tickCnt == 0);
      tickCnt = (tickCnt + 1) % tickDiv;
    end
  end

  // Count done pulses on the main DUT, sampled mid-cycle.
  always @(negedge clk) begin
    if (txDone === 1'b1) doneTotal++;
  end

  typedef struct {
    int          div;
    logic [7:0]  word;
    logic [10:0] exp;   // {stop, even parity, d7..d0, start}
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame as the bench captures it: parity bit present only with the macro.
  function automatic logic [10:0] view(input logic [10:0] e);
`ifdef UART_TX_PARITY_EN
    return e;
`else
    return {1'b0, e[10], e[8:0]};
`endif
  endfunction

  task automatic waitLevel(input string name, input logic level, input int limit, output int cyc);
    cyc = 0;
    while (txLine !== level && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(name, {31'b0, txLine}, {31'b0, level});
  endtask

  task automatic waitIdle(input string name);
    int cyc = 0;
    while (txReady !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(name, {31'b0, txReady}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    @(negedge clk);
    din     = w;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
  endtask

  // Wait for the start bit, then sample the middle of every bit period.
  task automatic captureFrame(input string name, output logic [10:0] line, output int readyHigh);
    int cyc;
    int bitClk = 16 * tickDiv;
    line = '0;
    readyHigh = 0;
    waitLevel({name, "_start"}, 1'b0, 4000, cyc);
    repeat (bitClk / 2) @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      line[k] = txLine;
      if (txReady === 1'b1) readyHigh++;
      if (k < NB - 1) repeat (bitClk) @(negedge clk);
    end
  endtask

  initial begin
    logic [10:0] line;
    int rh, cyc, d0, gap, total, low;

    vecs[0] = '{4, 8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{1, 8'h07, 11'b1_1_00000111_0};
    vecs[2] = '{2, 8'h81, 11'b1_0_10000001_0};
    vecs[3] = '{1, 8'h01, 11'b1_1_00000001_0};
    vecs[4] = '{1, 8'h00, 11'b1_0_00000000_0};
    vecs[5] = '{1, 8'hFE, 11'b1_1_11111110_0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", {31'b0, txLine}, 32'd1);
    checkOutput("rst_ready", {31'b0, txReady}, 32'd1);
    checkOutput("rst_busy", {31'b0, txBusy}, 32'd0);
    checkOutput("rst_done", {31'b0, txDone}, 32'd0);
    checkOutput("rst_long_tx", {31'b0, bTx}, 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      tickDiv = vecs[i].div;
      repeat (2) @(negedge clk);
      d0 = doneTotal;
      applyStimulus(vecs[i].word);
      captureFrame($sformatf("vec%0d", i), line, rh);
      waitIdle($sformatf("vec%0d_idle", i));
      checkOutput($sformatf("vec%0d_frame", i), {21'b0, line}, {21'b0, view(vecs[i].exp)});
      checkOutput($sformatf("vec%0d_done", i), doneTotal - d0, 32'd1);
      checkOutput($sformatf("vec%0d_busy", i), {31'b0, txBusy}, 32'd0);
    end

    // T1 bit length at 4 clk per tick: data bit 1 of 0xA5 is an isolated 0
    tickDiv = 4;
    repeat (2) @(negedge clk);
    applyStimulus(8'hA5);
    waitLevel("t1_start", 1'b0, 400, cyc);
    waitLevel("t1_d0", 1'b1, 400, cyc);
    waitLevel("t1_d1", 1'b0, 400, cyc);
    waitLevel("t1_d2", 1'b1, 400, cyc);
    checkOutput("t1_bit_clks", cyc, 32'd64);
    waitIdle("t1_idle");

    // T2 back-to-back: 0x3C held valid while 0x5A is in flight
    tickDiv = 1;
    repeat (2) @(negedge clk);
    din = 8'h5A;
    txValid = 1'b1;
    cyc = 0;
    while (txReady !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t2_accept", {31'b0, txReady}, 32'd0);
    din = 8'h3C;
    captureFrame("t2_first", line, rh);
    checkOutput("t2_first_frame", {21'b0, line}, {21'b0, view(11'b1_0_01011010_0)});
    cyc = 0;
    while (txDone !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t2_done", {31'b0, txDone}, 32'd1);
    @(negedge clk);
    checkOutput("t2_ready_after_done", {31'b0, txReady}, 32'd1);
    gap = 1;
    while (txLine !== 1'b0 && gap < 64) begin
      if (txReady === 1'b0) txValid = 1'b0;
      @(negedge clk);
      gap++;
    end
    txValid = 1'b0;
    checkOutput("t2_gap_lt_bit", {31'b0, (gap < 16)}, 32'd1);
    captureFrame("t2_second", line, rh);
    checkOutput("t2_second_frame", {21'b0, line}, {21'b0, view(11'b1_0_00111100_0)});
    waitIdle("t2_idle");

    // T3 tx_valid with 0xFF during the frame is ignored
    repeat (2) @(negedge clk);
    applyStimulus(8'h81);
    din = 8'hFF;
    txValid = 1'b1;
    captureFrame("t3", line, rh);
    txValid = 1'b0;
    checkOutput("t3_frame", {21'b0, line}, {21'b0, view(11'b1_0_10000001_0)});
    checkOutput("t3_ready_high_samples", rh, 32'd0);
    waitIdle("t3_idle");
    repeat (20) @(negedge clk);
    checkOutput("t3_no_extra_frame", {31'b0, txBusy}, 32'd0);

    // T4 reset in the middle of data bit 3
    repeat (2) @(negedge clk);
    applyStimulus(8'h00);
    waitLevel("t4_start", 1'b0, 100, cyc);
    repeat (16 * 4 + 8) @(negedge clk);
    checkOutput("t4_pre_tx", {31'b0, txLine}, 32'd0);
    d0 = doneTotal;
    reset_n = 1'b0;
    #1;
    checkOutput("t4_rst_tx", {31'b0, txLine}, 32'd1);
    checkOutput("t4_rst_busy", {31'b0, txBusy}, 32'd0);
    checkOutput("t4_rst_ready", {31'b0, txReady}, 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("t4_no_done", doneTotal - d0, 32'd0);
    applyStimulus(8'h81);
    captureFrame("t4_after", line, rh);
    checkOutput("t4_after_frame", {21'b0, line}, {21'b0, view(11'b1_0_10000001_0)});
    waitIdle("t4_idle");

    // T6 SB_TICK=32 with constant tick, word 0x00
    @(negedge clk);
    bDin = 8'h00;
    bValid = 1'b1;
    @(negedge clk);
    bValid = 1'b0;
    total = 0;
    low = 0;
    while (total < 1000) begin
      total++;
      if (bTx === 1'b0) low++;
      if (bDone === 1'b1) break;
      @(negedge clk);
    end
    checkOutput("t6_total_clks", total, 32'd176);
    checkOutput("t6_low_clks", low, 32'd144);
    checkOutput("t6_tx_at_done", {31'b0, bTx}, 32'd1);
    @(negedge clk);
    checkOutput("t6_ready", {31'b0, bReady}, 32'd1);

`ifdef UART_TX_PARITY_EN
    // T5 parity of 0x07: even sends 1, odd sends 0
    begin
      logic [10:0] eLine, oLine;
      @(negedge clk);
      pDin = 8'h07;
      pValid = 1'b1;
      @(negedge clk);
      pValid = 1'b0;
      cyc = 0;
      while (peTx !== 1'b0 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("t5_start", {31'b0, peTx}, 32'd0);
      repeat (8) @(negedge clk);
      for (int k = 0; k < 11; k++) begin
        eLine[k] = peTx;
        oLine[k] = poTx;
        if (k < 10) repeat (16) @(negedge clk);
      end
      checkOutput("t5_even_parity", {31'b0, eLine[9]}, 32'd1);
      checkOutput("t5_odd_parity", {31'b0, oLine[9]}, 32'd0);
      checkOutput("t5_even_frame", {21'b0, eLine}, {21'b0, 11'b1_1_00000111_0});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
